// File: rtl/clb_cfg_loader.sv
// clb_cfg_loader: serial configuration controller for a row of NCLB logic blocks.
// It hunts for a preamble in the DIN stream and then reads a 16-bit length field.
// Next it shifts in NCLB*CFGW data bits, first bit landing at the CFG MSB.
// A final bit gives even parity. Only a good-parity load is copied into CFG.
// CFG is copied in one atomic step, so partial or failed loads never reach it.
// Per-CLB word layout, MSB to LSB:
//   mem[15:0], comboption[1:0], mux2sel..mux6sel (2 bits each),
//   o2m1_0, o2m2_0, o2m3_0, o2m1_1, o2m2_1, o2m3_1, DQmux1, DQmux2, floporlatch
module clb_cfg_loader #(
   parameter int          NCLB = 2,
   parameter int          CFGW = 37,
   parameter logic [7:0]  PRE  = 8'b11110010
) (
   input  logic                   K,
   input  logic                   RSTN,
   input  logic                   PROG,
   input  logic                   DIN,
   input  logic                   DVALID,
   output logic [NCLB*CFGW-1:0]   CFG,
   output logic                   BUSY,
   output logic                   DONE,
   output logic                   ERR
);

   localparam int          TOTAL     = NCLB * CFGW;
   localparam logic [15:0] TOTAL_LEN = 16'(TOTAL);
   localparam logic [15:0] LAST_DATA = 16'(TOTAL - 1);
   localparam logic [15:0] LAST_LEN  = 16'd15;

   typedef enum logic [2:0] {
      S_SYNC,
      S_LEN,
      S_DATA,
      S_PAR,
      S_DONE,
      S_ERR
   } state_t;

   state_t                          state_q,  state_d;
   logic [7:0]                      window_q, window_d;
   logic [15:0]                     cnt_q,    cnt_d;
   logic [15:0]                     len_q,    len_d;
   logic [TOTAL-1:0]                shadow_q, shadow_d;
   logic                            par_q,    par_d;
   logic [NCLB-1:0][CFGW-1:0]       cfg_q,    cfg_d;
   logic                            done_q,   done_d;
   logic                            err_q,    err_d;

   // State and datapath registers; reset aborts any load and clears CFG.
   always_ff @(posedge K or negedge RSTN) begin
      if (!RSTN) begin
         state_q  <= S_SYNC;
         window_q <= '0;
         cnt_q    <= '0;
         len_q    <= '0;
         shadow_q <= '0;
         par_q    <= 1'b0;
         cfg_q    <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         window_q <= window_d;
         cnt_q    <= cnt_d;
         len_q    <= len_d;
         shadow_q <= shadow_d;
         par_q    <= par_d;
         cfg_q    <= cfg_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   // Next-state logic: PROG restarts the hunt and beats the DIN bit of the same cycle;
   // otherwise only cycles with DVALID=1 advance anything.
   always_comb begin
      state_d  = state_q;
      window_d = window_q;
      cnt_d    = cnt_q;
      len_d    = len_q;
      shadow_d = shadow_q;
      par_d    = par_q;
      cfg_d    = cfg_q;
      done_d   = done_q;
      err_d    = err_q;

      if (PROG) begin
         state_d  = S_SYNC;
         window_d = '0;
         cnt_d    = '0;
         par_d    = 1'b0;
         done_d   = 1'b0;
         err_d    = 1'b0;
      end else if (DVALID) begin
         case (state_q)
            S_SYNC: begin
               window_d = (window_q << 1) | {7'd0, DIN};
               if (window_d == PRE) begin
                  state_d = S_LEN;
                  cnt_d   = '0;
               end
            end
            S_LEN: begin
               len_d = (len_q << 1) | {15'd0, DIN};
               cnt_d = cnt_q + 16'd1;
               if (cnt_q == LAST_LEN) begin
                  cnt_d = '0;
                  // The length is checked up front so the data counter can never wrap.
                  if (len_d == TOTAL_LEN) begin
                     state_d = S_DATA;
                     par_d   = 1'b0;
                  end else begin
                     state_d = S_ERR;
                     err_d   = 1'b1;
                  end
               end
            end
            S_DATA: begin
               // A preamble pattern here is just data; there is no resync mid-load.
               shadow_d = (shadow_q << 1) | {{(TOTAL-1){1'b0}}, DIN};
               par_d    = par_q ^ DIN;
               cnt_d    = cnt_q + 16'd1;
               if (cnt_q == LAST_DATA) begin
                  state_d = S_PAR;
               end
            end
            S_PAR: begin
               // Even parity over data plus parity bit: the parity bit must equal the XOR of the data.
               if (DIN == par_q) begin
                  cfg_d   = shadow_q;
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_ERR;
               end
            end
            default: begin
               // Terminal states hold until PROG or reset.
            end
         endcase
      end
   end

   // Each CLB owns one CFGW-wide slice of the flat configuration bus.
   generate
      for (genvar gi = 0; gi < NCLB; gi++) begin : g_clb_out
         assign CFG[gi*CFGW +: CFGW] = cfg_q[gi];
      end
   endgenerate

   assign BUSY = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_PAR);
   assign DONE = done_q;
   assign ERR  = err_q;

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Testbench for clb_cfg_loader (NCLB=2): directed scenarios with random data words,
// predictions from a stream-level reference model.
module tb_clb_cfg_loader;

   localparam int NCLB  = 2;
   localparam int CFGW  = 37;
   localparam int TOTAL = NCLB * CFGW;

   logic              K      = 1'b0;
   logic              RSTN   = 1'b0;
   logic              PROG   = 1'b0;
   logic              DIN    = 1'b0;
   logic              DVALID = 1'b0;
   logic [TOTAL-1:0]  CFG;
   logic              BUSY;
   logic              DONE;
   logic              ERR;

   int checks = 0;
   int errors = 0;

   bit               stream[$];
   logic [7:0]       pre_v = 8'b11110010;
   logic [TOTAL-1:0] exp_cfg = '0;
   logic [TOTAL-1:0] t1_cfg;
   logic [TOTAL-1:0] pm_cfg;
   bit               pm_done;
   bit               pm_err;
   logic [CFGW-1:0]  w1, w0;
   int               n;

   clb_cfg_loader #(.NCLB(NCLB)) dut (
      .K      (K),
      .RSTN   (RSTN),
      .PROG   (PROG),
      .DIN    (DIN),
      .DVALID (DVALID),
      .CFG    (CFG),
      .BUSY   (BUSY),
      .DONE   (DONE),
      .ERR    (ERR)
   );

   always #5 K = ~K;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic push(input logic [127:0] v, input int nb);
      for (int i = nb - 1; i >= 0; i--) stream.push_back(v[i]);
   endtask

   // Preamble, length, data (first bit = CFG MSB), parity bit (optionally wrong).
   task automatic build(input logic [15:0] len, input logic [TOTAL-1:0] data, input bit flip);
      push(128'(pre_v), 8);
      push(128'(len), 16);
      push(128'(data), TOTAL);
      push(128'((^data) ^ flip), 1);
   endtask

   // Send stream[lo..hi-1]; with tog set every valid bit is followed by a stall cycle.
   task automatic send(input int lo, input int hi, input bit tog);
      for (int i = lo; i < hi; i++) begin
         @(negedge K);
         PROG = 1'b0; DIN = stream[i]; DVALID = 1'b1;
         if (tog) begin
            @(negedge K);
            DVALID = 1'b0; DIN = 1'($urandom);
         end
      end
      @(negedge K);
      DVALID = 1'b0; DIN = 1'($urandom);
   endtask

   task automatic prog_pulse();
      @(negedge K);
      PROG = 1'b1; DVALID = 1'($urandom); DIN = 1'($urandom);
      @(negedge K);
      PROG = 1'b0; DVALID = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge K);
      RSTN = 1'b0; DVALID = 1'b0; PROG = 1'b0;
      @(negedge K);
      RSTN = 1'b1;
      exp_cfg = '0;
   endtask

   // Reference model over the sequence of valid bits since the last restart:
   // locate the first 8-bit slice equal to the preamble, read the length as a number,
   // then take the data bits and accept them only if the count of ones (data + parity) is even.
   function automatic void predict(input bit q[$], output bit p_done, output bit p_err,
                                   output logic [TOTAL-1:0] p_cfg);
      int pos, len, ones;
      bit match;
      p_done = 1'b0; p_err = 1'b0; p_cfg = '0; pos = -1;
      for (int i = 7; i < q.size(); i++) begin
         match = 1'b1;
         for (int k = 0; k < 8; k++) if (q[i-7+k] != pre_v[7-k]) match = 1'b0;
         if (match) begin
            pos = i + 1;
            break;
         end
      end
      if (pos < 0 || q.size() < pos + 16) return;
      len = 0;
      for (int k = 0; k < 16; k++) len = len * 2 + int'(q[pos+k]);
      if (len != TOTAL) begin
         p_err = 1'b1;
         return;
      end
      if (q.size() < pos + 16 + TOTAL + 1) return;
      ones = 0;
      for (int k = 0; k < TOTAL; k++) begin
         p_cfg[TOTAL-1-k] = q[pos+16+k];
         ones += int'(q[pos+16+k]);
      end
      ones += int'(q[pos+16+TOTAL]);
      if (ones % 2 == 0) p_done = 1'b1;
      else               p_err  = 1'b1;
   endfunction

   task automatic apply_model();
      predict(stream, pm_done, pm_err, pm_cfg);
      if (pm_done) exp_cfg = pm_cfg;
   endtask

   task automatic check_result(input string tag);
      check({tag, "_done"}, 128'(DONE), 128'(pm_done));
      check({tag, "_err"},  128'(ERR),  128'(pm_err));
      check({tag, "_cfg"},  128'(CFG),  128'(exp_cfg));
      check({tag, "_busy"}, 128'(BUSY), 128'(0));
   endtask

   initial begin
      // Reset values
      RSTN = 1'b0;
      repeat (2) @(negedge K);
      check("rst_cfg",  128'(CFG),  128'(0));
      check("rst_busy", 128'(BUSY), 128'(0));
      check("rst_done", 128'(DONE), 128'(0));
      check("rst_err",  128'(ERR),  128'(0));
      RSTN = 1'b1;

      // Test 1: clean load, phase-by-phase BUSY
      w1 = {5'($urandom), 32'($urandom)};
      w0 = {16'h0116, 21'd0};
      stream.delete();
      build(16'h004A, {w1, w0}, 1'b0);
      send(0, 8, 1'b0);
      check("t1_busy_len", 128'(BUSY), 128'(1));
      check("t1_done_len", 128'(DONE), 128'(0));
      send(8, 24, 1'b0);
      check("t1_busy_data", 128'(BUSY), 128'(1));
      send(24, 24 + TOTAL, 1'b0);
      check("t1_busy_par", 128'(BUSY), 128'(1));
      check("t1_cfg_hold", 128'(CFG),  128'(exp_cfg));
      send(24 + TOTAL, stream.size(), 1'b0);
      apply_model();
      check_result("t1");
      check("t1_clb0_mem", 128'(CFG[36:21]), 128'(16'h0116));
      check("t1_clb0_rest", 128'(CFG[20:0]), 128'(0));
      check("t1_clb1", 128'(CFG[73:37]), 128'(w1));
      t1_cfg = exp_cfg;
      $display("t1 clean load cfg=%h done=%0d", CFG, DONE);

      // Test 2: wrong parity, then PROG and a good load
      do_reset();
      stream.delete();
      build(16'h004A, {w1, w0}, 1'b1);
      send(0, stream.size(), 1'b0);
      apply_model();
      check_result("t2_bad");
      prog_pulse();
      check("t2_prog_err",  128'(ERR),  128'(0));
      check("t2_prog_done", 128'(DONE), 128'(0));
      stream.delete();
      build(16'h004A, {5'($urandom), 32'($urandom), 5'($urandom), 32'($urandom)}, 1'b0);
      send(0, stream.size(), 1'b0);
      apply_model();
      check_result("t2_good");
      $display("t2 bad parity then reload cfg=%h done=%0d", CFG, DONE);

      // Test 3: wrong length
      prog_pulse();
      stream.delete();
      build(16'h004B, {5'($urandom), 32'($urandom), 5'($urandom), 32'($urandom)}, 1'b0);
      send(0, 24, 1'b0);
      apply_model();
      check("t3_err",  128'(ERR),  128'(1));
      check("t3_busy", 128'(BUSY), 128'(0));
      check("t3_cfg",  128'(CFG),  128'(exp_cfg));
      send(24, stream.size(), 1'b0);
      check_result("t3_tail");
      $display("t3 length 004B err=%0d cfg=%h", ERR, CFG);

      // Test 4: leading garbage, DVALID toggling throughout
      do_reset();
      stream.delete();
      push(128'(12'b1011_0111_1111), 12);
      build(16'h004A, {w1, w0}, 1'b0);
      send(0, stream.size(), 1'b1);
      apply_model();
      check_result("t4");
      check("t4_same_as_t1", 128'(CFG), 128'(t1_cfg));
      $display("t4 garbage+stall load cfg=%h done=%0d", CFG, DONE);

      // Test 5a: async reset mid-DATA
      prog_pulse();
      stream.delete();
      build(16'h004A, {5'($urandom), 32'($urandom), 5'($urandom), 32'($urandom)}, 1'b0);
      send(0, 24 + 30, 1'b0);
      check("t5_busy_mid", 128'(BUSY), 128'(1));
      #1 RSTN = 1'b0;
      #1;
      check("t5_rst_cfg",  128'(CFG),  128'(0));
      check("t5_rst_done", 128'(DONE), 128'(0));
      check("t5_rst_busy", 128'(BUSY), 128'(0));
      @(negedge K);
      RSTN = 1'b1;
      exp_cfg = '0;
      $display("t5 async reset mid-data cfg=%h busy=%0d", CFG, BUSY);

      // Test 5b: fresh load from SYNC, then PROG mid-DATA keeps it
      stream.delete();
      build(16'h004A, {5'($urandom), 32'($urandom), 5'($urandom), 32'($urandom)}, 1'b0);
      send(0, stream.size(), 1'b0);
      apply_model();
      check_result("t5_load");
      prog_pulse();
      stream.delete();
      build(16'h004A, {5'($urandom), 32'($urandom), 5'($urandom), 32'($urandom)}, 1'b0);
      send(0, 24 + 40, 1'b0);
      prog_pulse();
      check("t5_prog_cfg",  128'(CFG),  128'(exp_cfg));
      check("t5_prog_done", 128'(DONE), 128'(0));
      check("t5_prog_busy", 128'(BUSY), 128'(0));
      $display("t5 prog mid-data cfg=%h done=%0d", CFG, DONE);

      // Test 6: PROG together with the preamble-completing bit
      stream.delete();
      push(128'(pre_v), 8);
      send(0, 7, 1'b0);
      @(negedge K);
      PROG = 1'b1; DIN = 1'b0; DVALID = 1'b1;
      @(negedge K);
      PROG = 1'b0; DVALID = 1'b0;
      check("t6_prog_wins", 128'(BUSY), 128'(0));
      stream.delete();
      push(128'(0), 1);
      build(16'h004A, {5'($urandom), 32'($urandom), 5'($urandom), 32'($urandom)}, 1'b0);
      send(0, 1, 1'b0);
      check("t6_window_cleared", 128'(BUSY), 128'(0));
      send(1, 9, 1'b0);
      check("t6_full_pre", 128'(BUSY), 128'(1));
      send(9, stream.size(), 1'b0);
      apply_model();
      check_result("t6");
      $display("t6 prog vs preamble cfg=%h done=%0d", CFG, DONE);

      // Randomized loads: random data, random parity error, random stalls
      for (int r = 0; r < 6; r++) begin
         prog_pulse();
         stream.delete();
         n = int'($urandom_range(0, 5));
         for (int g = 0; g < n; g++) stream.push_back(1'b0);
         build(16'h004A, {5'($urandom), 32'($urandom), 5'($urandom), 32'($urandom)},
               1'($urandom_range(0, 1)));
         send(0, stream.size(), 1'($urandom_range(0, 1)));
         apply_model();
         check_result("rand");
         $display("rand load %0d done=%0d err=%0d cfg=%h", r, DONE, ERR, CFG);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/clb_cfg_loader.md
Name: clb_cfg_loader

Overview:
- Serial configuration controller for a row of NCLB logic blocks. It replaces the fixed power-up config values with a loaded bitstream.
- Hunts for a preamble in a serial stream, checks a length field, then shifts in one 37-bit config word per CLB and checks even parity.
- Transfers the words to the CLB config outputs atomically. Sits between the external config pin interface and the CLB array.

Parameters:
- NCLB, 2, number of CLBs configured; range 1..64.
- CFGW, 37, config bits per CLB; fixed layout, do not override.
- PRE, 8'b11110010, preamble pattern, matched MSB-first.

Ports:
- K  input  1  clock; all state on rising edge.
- RSTN  input  1  asynchronous active-low reset.
- PROG  input  1  synchronous restart request.
- DIN  input  1  serial config bit.
- DVALID  input  1  DIN qualifier; only cycles with DVALID=1 consume a bit.
- CFG  output  NCLB*CFGW  config words; CLB i owns CFG[i*CFGW +: CFGW].
- BUSY  output  1  high in LEN, DATA and PAR.
- DONE  output  1  configuration accepted.
- ERR  output  1  length or parity failure.

Behaviour:
- Per-CLB word layout, MSB to LSB:
  - mem[15:0], comboption[1:0]
  - mux2sel, mux3sel, mux4sel, mux5sel, mux6sel (2 bits each)
  - o2m1_0, o2m2_0, o2m3_0, o2m1_1, o2m2_1, o2m3_1
  - DQmux1, DQmux2, floporlatch
- Reset (RSTN=0, asynchronous): state=SYNC, CFG=0, shadow=0, window=0, bit counter=0, BUSY=0, DONE=0, ERR=0.
- States and transitions (bit = a cycle with DVALID=1):
  - SYNC: shift DIN into an 8-bit window (new bit in LSB). When the post-shift window equals PRE, go to LEN next edge and clear the counter.
  - LEN: shift 16 bits MSB-first into the length register. After the 16th bit: length == NCLB*CFGW goes to DATA; otherwise go to ERRS.
  - DATA: shift DIN into the LSB of the NCLB*CFGW-bit shadow (shift left) and XOR it into a parity accumulator. After the NCLB*CFGW-th bit go to PAR. The first data bit ends at CFG MSB.
  - PAR: one bit. DIN == accumulator (even parity over data+parity): CFG<=shadow, DONE<=1, go to DONEST. Else ERR<=1, go to ERRS. CFG update and DONE assert on the same edge.
  - DONEST / ERRS: ignore DIN and DVALID; hold outputs.
- PROG=1 in any state has priority over the DIN bit that cycle. Next edge: state=SYNC, window, counter and parity cleared, DONE=0, ERR=0. CFG keeps its last accepted value.
- CFG changes only on a good-parity PAR edge or on reset. Partial or failed loads never disturb it.
- DVALID=0 cycles stall every state with no change. There is no timeout.
- The counter is 16 bits wide; DATA never wraps because the length is checked first.
- PRE found again in DATA is treated as data, not a resync.
- RSTN assertion mid-load aborts the load immediately; CFG returns to 0.

Test Plan:
1. NCLB=2: reset, stream 1111_0010, length 16'h004A, 74 data bits (CLB1 word then CLB0 word), correct parity.
   - Response: BUSY high from LEN to PAR; DONE=1 at the edge after the parity bit.
   - Response: CFG[73:37]=CLB1 word and CFG[36:0]=CLB0 word. CLB0 mem field = 16'h0116, all other fields 0.
2. Same stream with the parity bit inverted.
   - Response: ERR=1, DONE=0, CFG stays 0.
   - Then PROG pulse and a valid stream: ERR=0, then DONE=1 with new CFG.
3. Length 16'h004B.
   - Response: ERR=1 on the edge after the 16th length bit. DATA is never entered and CFG is unchanged.
4. Leading garbage 1011_0111_1111 before the preamble, with DVALID toggling 1-0-1 every cycle through the whole stream.
   - Response: preamble is still detected and the load completes identically to test 1.
5. After a successful load, start a second load and assert RSTN=0 mid-DATA.
   - Response: CFG=0 asynchronously, DONE=0, BUSY=0, state SYNC.
   - Separately, PROG mid-DATA (no reset): CFG keeps the first load.
6. PROG and a preamble-completing bit in the same cycle.
   - Response: PROG wins; state is SYNC and the window is cleared. A full fresh preamble is required before LEN.
